// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed loads and stores into whole-word accesses on a
// 64-bit data memory, doing lane extraction for loads and read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int DEPTH_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [63:0] mem_wr_data,
  input  logic [63:0] mem_rd_data,
  output logic [2:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready; req_ready
  // is high only in IDLE, so a request held while busy is not consumed until the unit idles.
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] merged_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        req_illegal;
  logic        req_misaligned;
  logic        req_out_of_range;
  logic        req_err;

  logic [5:0]  shamt;
  logic [63:0] shifted;
  logic [63:0] load_val;
  logic [63:0] byte_mask;
  logic [63:0] lane_mask;
  logic [63:0] merged;

  assign accept = req_valid && req_ready;

  always_comb begin
    req_illegal = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
    case (req_funct3[1:0])
      2'b01:   req_misaligned = req_addr[0];
      2'b10:   req_misaligned = |req_addr[1:0];
      2'b11:   req_misaligned = |req_addr[2:0];
      default: req_misaligned = 1'b0;
    endcase
    req_out_of_range = {3'b000, req_addr[63:3]} >= 64'(DEPTH_WORDS);
    req_err = req_illegal || req_misaligned || req_out_of_range;
  end

  // Lane 0 of the addressed access is brought down to bit 0 before extension.
  assign shamt   = {addr_q[2:0], 3'b000};
  assign shifted = mem_rd_data >> shamt;

  always_comb begin
    case (f3_q)
      3'b000:  load_val = {{56{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_val = {{32{shifted[31]}}, shifted[31:0]};
      3'b011:  load_val = shifted;
      3'b100:  load_val = {56'd0, shifted[7:0]};
      3'b101:  load_val = {48'd0, shifted[15:0]};
      3'b110:  load_val = {32'd0, shifted[31:0]};
      default: load_val = 64'd0;
    endcase
  end

  always_comb begin
    case (f3_q[1:0])
      2'b00:   byte_mask = 64'h0000_0000_0000_00FF;
      2'b01:   byte_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   byte_mask = 64'h0000_0000_FFFF_FFFF;
      default: byte_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    lane_mask = byte_mask << shamt;
    merged    = (mem_rd_data & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                              state_d = RESP;
          else if (req_we && req_funct3 == 3'b011)  state_d = WR;
          else                                      state_d = RD;
        end
      end
      RD:      state_d = CAP;
      CAP:     state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      f3_q     <= 3'd0;
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      merged_q <= 64'd0;
      rdata_q  <= 64'd0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= req_we;
        f3_q     <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        err_q    <= req_err;
        merged_q <= 64'd0;
        rdata_q  <= 64'd0;
      end
      if (state_q == CAP) begin
        if (we_q) merged_q <= merged;
        else      rdata_q  <= load_val;
      end
    end
  end

  // Every output is gated by reset so nothing leaks out of an aborted request.
  always_comb begin
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_rdata  = 64'd0;
    resp_err    = 1'b0;
    mem_addr    = 64'd0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_wr_data = 64'd0;
    dbg_state   = 3'd0;
    if (!reset) begin
      dbg_state = state_q;
      case (state_q)
        IDLE: req_ready = 1'b1;
        RD: begin
          mem_rd   = 1'b1;
          mem_addr = {3'b000, addr_q[63:3]};
        end
        WR: begin
          mem_wr      = 1'b1;
          mem_addr    = {3'b000, addr_q[63:3]};
          mem_wr_data = (f3_q == 3'b011) ? wdata_q : merged_q;
        end
        RESP: begin
          resp_valid = 1'b1;
          resp_rdata = rdata_q;
          resp_err   = err_q;
        end
        default: ;
      endcase
    end
  end

endmodule
